flick_conditioner: RTL



---
 rtl/flick_pkg.sv | 20 ++
 rtl/step_tick_gen.sv | 41 ++++
 rtl/flick_conditioner.sv | 120 ++++++++++++
 3 files changed

// File: rtl/flick_pkg.sv
// flick_pkg: shared definitions for the flick button front end and the
// bound-flash lamp sequencer.
//   deb_state_t      - debounce FSM state encoding
//   DEB_CYCLES_DEF   - default debounce length in clk cycles
//   STEP_CYCLES_DEF  - default lamp step period in clk cycles
//   LAMP_W           - lamp vector width used by the sequencer
package flick_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } deb_state_t;

  localparam int DEB_CYCLES_DEF  = 1_000_000;
  localparam int STEP_CYCLES_DEF = 12_500_000;
  localparam int LAMP_W          = 16;

endpackage

// File: rtl/step_tick_gen.sv
// step_tick_gen: periodic one-cycle strobe that paces the lamp sequencer.
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   step_run - 1 = timer runs, 0 = timer held at 0
//   step_en  - registered strobe, one cycle every STEP_CYCLES cycles
module step_tick_gen
  import flick_pkg::*;
#(
  parameter int STEP_CYCLES = STEP_CYCLES_DEF,
  localparam int STP_W = $clog2(STEP_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step_run,
  output logic step_en
);

  localparam logic [STP_W-1:0] STP_LAST = STP_W'(STEP_CYCLES - 1);

  logic [STP_W-1:0] cnt;

  // Strobe is registered on the wrap edge, so the first one lands
  // STEP_CYCLES edges after step_run is first sampled high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      step_en <= 1'b0;
    end else if (!step_run) begin
      cnt     <= '0;
      step_en <= 1'b0;
    end else if (cnt == STP_LAST) begin
      cnt     <= '0;
      step_en <= 1'b1;
    end else begin
      cnt     <= cnt + STP_W'(1);
      step_en <= 1'b0;
    end
  end

endmodule

// File: rtl/flick_conditioner.sv
// flick_conditioner: cleans up the raw flick button for the lamp sequencer
// and generates the sequencer's step strobe.
// Ports:
//   clk         - system clock, rising edge
//   rst_n       - asynchronous active-low reset
//   flick_raw   - raw button, asynchronous, may bounce
//   flick_ack   - one-cycle pulse from the sequencer consuming flick_req
//   step_run    - enables the step timer
//   flick       - debounced level
//   flick_pulse - one cycle on each debounced rising edge
//   flick_req   - sticky request, set by a press, cleared by flick_ack
//   step_en     - one-cycle step strobe
module flick_conditioner
  import flick_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int STEP_CYCLES = STEP_CYCLES_DEF,
  localparam int CNT_W = $clog2(DEB_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flick_raw,
  input  logic flick_ack,
  input  logic step_run,
  output logic flick,
  output logic flick_pulse,
  output logic flick_req,
  output logic step_en
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic       s1;
  logic       s;
  deb_state_t state;
  logic [CNT_W-1:0] cnt;
  logic       rise_commit;

  // Two-flop synchroniser; only s is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= flick_raw;
      s  <= s1;
    end
  end

  assign rise_commit = (state == WAIT_HI) && s && (cnt == CNT_LAST);

  // Debounce FSM plus request latch. The request is set both on the commit
  // edge (so it rises together with flick_pulse) and while flick_pulse is
  // high, so an ack arriving in the pulse cycle cannot cancel a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE_LO;
      cnt         <= '0;
      flick       <= 1'b0;
      flick_pulse <= 1'b0;
      flick_req   <= 1'b0;
    end else begin
      flick_pulse <= 1'b0;
      case (state)
        IDLE_LO: begin
          if (s) begin
            state <= WAIT_HI;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT_HI: begin
          if (!s) begin
            state <= IDLE_LO;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= IDLE_HI;
            cnt         <= '0;
            flick       <= 1'b1;
            flick_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        IDLE_HI: begin
          if (!s) begin
            state <= WAIT_LO;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT_LO: begin
          if (s) begin
            state <= IDLE_HI;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_LO;
            cnt   <= '0;
            flick <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE_LO;
          cnt   <= '0;
        end
      endcase
      flick_req <= rise_commit | flick_pulse | (flick_req & ~flick_ack);
    end
  end

  step_tick_gen #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_step (
    .clk     (clk),
    .rst_n   (rst_n),
    .step_run(step_run),
    .step_en (step_en)
  );

endmodule
